// File: rtl/cb_stream_regs_bank.sv
// Per-stream CB recovery configuration and statistics snapshot register bank.
// Optional build macro CB_SNAP_CLEAR_ON_READ_EN: o_stat_clr follows o_stat_req (counters become deltas).
module cb_stream_regs_bank #(
   parameter int REG_ADDR_BUS_WIDTH = 8,
   parameter int REG_DATA_BUS_WIDTH = 16,
   parameter int STREAM_NUM         = 64,
   parameter int STREAM_IDX_W       = 8,
   parameter int MAX_HIST           = 32,
   parameter int SNAP_TIMEOUT       = 255
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_switch_reg_bus_we,
   input  logic [REG_ADDR_BUS_WIDTH-1:0] i_switch_reg_bus_we_addr,
   input  logic [REG_DATA_BUS_WIDTH-1:0] i_switch_reg_bus_we_din,
   input  logic                          i_switch_reg_bus_we_din_v,
   input  logic                          i_switch_reg_bus_rd,
   input  logic [REG_ADDR_BUS_WIDTH-1:0] i_switch_reg_bus_rd_addr,
   output logic [REG_DATA_BUS_WIDTH-1:0] o_switch_reg_bus_rd_dout,
   output logic                          o_switch_reg_bus_rd_dout_v,
   input  logic [STREAM_IDX_W-1:0]       i_lkup_stream,
   output logic [7:0]                    o_lkup_alg_id,
   output logic [7:0]                    o_lkup_hist_len,
   output logic [15:0]                   o_lkup_reset_msec,
   output logic                          o_lkup_en,
   output logic                          o_stat_req,
   output logic [STREAM_IDX_W-1:0]       o_stat_stream,
   output logic                          o_stat_clr,
   input  logic                          i_stat_ack,
   input  logic [63:0]                   i_stat_passed,
   input  logic [63:0]                   i_stat_discarded,
   input  logic [31:0]                   i_stat_resets
);

   localparam int AW     = REG_ADDR_BUS_WIDTH;
   localparam int DW     = REG_DATA_BUS_WIDTH;
   localparam int LW     = STREAM_IDX_W + 1;
   localparam int SIDX_W = (STREAM_NUM > 1) ? $clog2(STREAM_NUM) : 1;
   localparam int TMR_W  = (SNAP_TIMEOUT > 1) ? $clog2(SNAP_TIMEOUT) : 1;

   localparam logic [AW-1:0] A_SEL   = AW'(8'h00);
   localparam logic [AW-1:0] A_ALG   = AW'(8'h01);
   localparam logic [AW-1:0] A_HIST  = AW'(8'h02);
   localparam logic [AW-1:0] A_MSEC  = AW'(8'h03);
   localparam logic [AW-1:0] A_EN    = AW'(8'h04);
   localparam logic [AW-1:0] A_SNAP  = AW'(8'h05);
   localparam logic [AW-1:0] A_P0    = AW'(8'h06);
   localparam logic [AW-1:0] A_P1    = AW'(8'h07);
   localparam logic [AW-1:0] A_P2    = AW'(8'h08);
   localparam logic [AW-1:0] A_P3    = AW'(8'h09);
   localparam logic [AW-1:0] A_D0    = AW'(8'h0A);
   localparam logic [AW-1:0] A_D1    = AW'(8'h0B);
   localparam logic [AW-1:0] A_D2    = AW'(8'h0C);
   localparam logic [AW-1:0] A_D3    = AW'(8'h0D);
   localparam logic [AW-1:0] A_R0    = AW'(8'h0E);
   localparam logic [AW-1:0] A_R1    = AW'(8'h0F);
   localparam logic [AW-1:0] A_SSTRM = AW'(8'h10);
   localparam logic [AW-1:0] A_NUM   = AW'(8'h11);

   localparam logic [DW-1:0]    NUM_D      = DW'(STREAM_NUM);
   localparam logic [LW-1:0]    NUM_L      = LW'(STREAM_NUM);
   localparam logic [7:0]       MAX_HIST_B = 8'(MAX_HIST);
   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(SNAP_TIMEOUT - 1);

   typedef struct packed {
      logic [7:0]  alg_id;
      logic [7:0]  hist_len;
      logic [15:0] reset_msec;
      logic        en;
   } cfg_t;

   localparam cfg_t CFG_RST = '{alg_id: 8'h00, hist_len: 8'h04, reset_msec: 16'h03E8, en: 1'b0};

   typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} snap_st_t;

   // Host bus capture stage
   logic          we_q;
   logic [AW-1:0] we_addr_q;
   logic [DW-1:0] we_din_q;
   logic          we_din_v_q;
   logic          rd_q;
   logic [AW-1:0] rd_addr_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         we_q       <= 1'b0;
         we_addr_q  <= '0;
         we_din_q   <= '0;
         we_din_v_q <= 1'b0;
         rd_q       <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         we_q       <= i_switch_reg_bus_we;
         we_addr_q  <= i_switch_reg_bus_we_addr;
         we_din_q   <= i_switch_reg_bus_we_din;
         we_din_v_q <= i_switch_reg_bus_we_din_v;
         rd_q       <= i_switch_reg_bus_rd;
         rd_addr_q  <= i_switch_reg_bus_rd_addr;
      end
   end

   logic              wr_ok;
   logic [DW-1:0]     sel_q;
   logic              sel_ok;
   logic [SIDX_W-1:0] sel_idx;
   logic [7:0]        hist_d;
   logic              start_d;

   assign wr_ok   = we_q & we_din_v_q;
   assign sel_ok  = (sel_q < NUM_D);
   assign sel_idx = sel_q[SIDX_W-1:0];
   assign start_d = wr_ok && (we_addr_q == A_SNAP) && we_din_q[0];

   always_comb begin
      hist_d = we_din_q[7:0];
      if (we_din_q[7:0] == 8'd0) begin
         hist_d = 8'd1;
      end else if (we_din_q[7:0] > MAX_HIST_B) begin
         hist_d = MAX_HIST_B;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sel_q <= '0;
      end else if (wr_ok && (we_addr_q == A_SEL)) begin
         sel_q <= we_din_q;
      end
   end

   // Per-stream configuration table; every entry needs its own reset value
   cfg_t cfg_q [STREAM_NUM];
   cfg_t rd_cfg;

   assign rd_cfg = cfg_q[sel_idx];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < STREAM_NUM; i++) begin
            cfg_q[i] <= CFG_RST;
         end
      end else if (wr_ok && sel_ok) begin
         case (we_addr_q)
            A_ALG:   cfg_q[sel_idx].alg_id     <= we_din_q[7:0];
            A_HIST:  cfg_q[sel_idx].hist_len   <= hist_d;
            A_MSEC:  cfg_q[sel_idx].reset_msec <= we_din_q[15:0];
            A_EN:    cfg_q[sel_idx].en         <= we_din_q[0];
            default: ;
         endcase
      end
   end

   // Datapath lookup: out-of-range indices see the reset entry, disabled
   logic              lk_ok;
   logic [SIDX_W-1:0] lk_idx;
   cfg_t              lk_q;

   assign lk_ok  = ({1'b0, i_lkup_stream} < NUM_L);
   assign lk_idx = i_lkup_stream[SIDX_W-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lk_q <= CFG_RST;
      end else if (lk_ok) begin
         lk_q <= cfg_q[lk_idx];
      end else begin
         lk_q <= CFG_RST;
      end
   end

   assign o_lkup_alg_id     = lk_q.alg_id;
   assign o_lkup_hist_len   = lk_q.hist_len;
   assign o_lkup_reset_msec = lk_q.reset_msec;
   assign o_lkup_en         = lk_q.en;

   // Snapshot FSM with shadow counters
   snap_st_t          st_q;
   logic              stat_req_q;
   logic [STREAM_IDX_W-1:0] stat_stream_q;
   logic              done_q;
   logic              err_q;
   logic [TMR_W-1:0]  tmr_q;
   logic [63:0]       pass_sh_q;
   logic [63:0]       disc_sh_q;
   logic [31:0]       res_sh_q;
   logic              busy;

   assign busy = (st_q == ST_REQ);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st_q          <= ST_IDLE;
         stat_req_q    <= 1'b0;
         stat_stream_q <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         tmr_q         <= '0;
         pass_sh_q     <= '0;
         disc_sh_q     <= '0;
         res_sh_q      <= '0;
      end else begin
         case (st_q)
            ST_IDLE: begin
               if (start_d) begin
                  done_q <= 1'b0;
                  if (sel_ok) begin
                     st_q          <= ST_REQ;
                     stat_req_q    <= 1'b1;
                     stat_stream_q <= sel_q[STREAM_IDX_W-1:0];
                     tmr_q         <= '0;
                     err_q         <= 1'b0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               // Ack wins over a simultaneous timeout
               if (i_stat_ack) begin
                  st_q       <= ST_IDLE;
                  stat_req_q <= 1'b0;
                  done_q     <= 1'b1;
                  pass_sh_q  <= i_stat_passed;
                  disc_sh_q  <= i_stat_discarded;
                  res_sh_q   <= i_stat_resets;
               end else if (tmr_q == TMR_LAST) begin
                  st_q       <= ST_IDLE;
                  stat_req_q <= 1'b0;
                  err_q      <= 1'b1;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            default: begin
               st_q       <= ST_IDLE;
               stat_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_stat_req    = stat_req_q;
   assign o_stat_stream = stat_stream_q;

`ifdef CB_SNAP_CLEAR_ON_READ_EN
   assign o_stat_clr = stat_req_q;
`else
   assign o_stat_clr = 1'b0;
`endif

   // Read decode; counter words come only from the shadow copy
   logic [DW-1:0] rd_data_d;
   logic [DW-1:0] rd_dout_q;
   logic          rd_dout_v_q;

   always_comb begin
      rd_data_d = '0;
      case (rd_addr_q)
         A_SEL:   rd_data_d = sel_q;
         A_ALG:   if (sel_ok) rd_data_d = DW'(rd_cfg.alg_id);
         A_HIST:  if (sel_ok) rd_data_d = DW'(rd_cfg.hist_len);
         A_MSEC:  if (sel_ok) rd_data_d = DW'(rd_cfg.reset_msec);
         A_EN:    if (sel_ok) rd_data_d = DW'(rd_cfg.en);
         A_SNAP:  rd_data_d = DW'({err_q, done_q, busy});
         A_P0:    rd_data_d = DW'(pass_sh_q[15:0]);
         A_P1:    rd_data_d = DW'(pass_sh_q[31:16]);
         A_P2:    rd_data_d = DW'(pass_sh_q[47:32]);
         A_P3:    rd_data_d = DW'(pass_sh_q[63:48]);
         A_D0:    rd_data_d = DW'(disc_sh_q[15:0]);
         A_D1:    rd_data_d = DW'(disc_sh_q[31:16]);
         A_D2:    rd_data_d = DW'(disc_sh_q[47:32]);
         A_D3:    rd_data_d = DW'(disc_sh_q[63:48]);
         A_R0:    rd_data_d = DW'(res_sh_q[15:0]);
         A_R1:    rd_data_d = DW'(res_sh_q[31:16]);
         A_SSTRM: rd_data_d = DW'(stat_stream_q);
         A_NUM:   rd_data_d = NUM_D;
         default: rd_data_d = '0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_dout_q   <= '0;
         rd_dout_v_q <= 1'b0;
      end else begin
         rd_dout_v_q <= rd_q;
         rd_dout_q   <= rd_q ? rd_data_d : '0;
      end
   end

   assign o_switch_reg_bus_rd_dout   = rd_dout_q;
   assign o_switch_reg_bus_rd_dout_v = rd_dout_v_q;

endmodule

// File: doc/cb_stream_regs_bank.md
# cb_stream_regs_bank

Per-stream configuration and statistics register bank for the CB (FRER sequence recovery) function, parametrised in stream count. Host register bus selects a stream, reads and writes its recovery parameters, and triggers atomic snapshots of its 64/32-bit counters from the CB statistics block. The CB datapath reads per-stream configuration through a registered lookup port.

## Interface
- REG_ADDR_BUS_WIDTH, 8, register bus address width
- REG_DATA_BUS_WIDTH, 16, register bus data width (≥16)
- STREAM_NUM, 64, number of streams (2..256)
- STREAM_IDX_W, 8, stream index width
- MAX_HIST, 32, largest legal history length
- SNAP_TIMEOUT, 255, ack timeout in cycles (≥1)
- i_clk  in  1  clock, 250 MHz
- i_rst  in  1  asynchronous, active-high reset
- i_switch_reg_bus_we / _we_addr / _we_din / _we_din_v  in  1/ADDR/DATA/1  host write strobe, address, data, data valid
- i_switch_reg_bus_rd / _rd_addr  in  1/ADDR  host read strobe, address
- o_switch_reg_bus_rd_dout / _rd_dout_v  out  DATA/1  read data, read valid
- i_lkup_stream  in  STREAM_IDX_W  datapath config lookup index
- o_lkup_alg_id / o_lkup_hist_len / o_lkup_reset_msec / o_lkup_en  out  8/8/16/1  lookup result
- o_stat_req  out  1  snapshot request to statistics block
- o_stat_stream  out  STREAM_IDX_W  stream being snapshotted
- o_stat_clr  out  1  clear-after-snapshot qualifier (see Configuration)
- i_stat_ack  in  1  counters valid this cycle
- i_stat_passed / i_stat_discarded / i_stat_resets  in  64/64/32  counter values sampled on i_stat_ack

## Operation
- Host inputs registered one cycle before decode; write applies only when registered we and din_v both high.
- Address map: 0x00 STREAM_SEL rw; 0x01 ALG_ID rw[7:0]; 0x02 HIST_LEN rw[7:0]; 0x03 RESET_MSEC rw[15:0]; 0x04 STREAM_EN rw[0]; 0x05 SNAP_CTRL (write bit0=1 starts; read {err,done,busy} in [2:0]); 0x06–0x09 PASSED words low→high; 0x0A–0x0D DISCARDED; 0x0E–0x0F RESETS; 0x10 SNAP_STREAM ro; 0x11 STREAM_NUM ro. Unmapped reads return 0; unmapped writes ignored.
- 0x01–0x04 address the entry indexed by STREAM_SEL. STREAM_SEL ≥ STREAM_NUM: writes ignored, reads return 0.
- HIST_LEN write of 0 stores 1; write > MAX_HIST stores MAX_HIST.
- Per-stream reset values: ALG_ID 0x00, HIST_LEN 0x04, RESET_MSEC 0x03E8, STREAM_EN 0. STREAM_SEL resets to 0.
- Snapshot FSM: IDLE → (start write) REQ: latch STREAM_SEL into o_stat_stream, clear done/err, set busy, assert o_stat_req. REQ → IDLE on i_stat_ack: capture all three counters into shadow, set done. REQ → IDLE after SNAP_TIMEOUT cycles without ack: set err; shadow unchanged.
- Start write while busy is ignored. Start with STREAM_SEL out of range: no request, err=1 the next cycle.
- Counter word reads return only shadow contents, so multi-word reads are atomic per snapshot.
- Lookup: i_lkup_stream out of range returns reset values with o_lkup_en=0.

## Timing
- All outputs 0 in reset, except o_lkup_hist_len=4 and o_lkup_reset_msec=0x03E8.
- Write: register value updated 2 cycles after the input strobe edge; visible on lookup on the following lookup sample.
- Read: rd_dout_v high exactly 2 cycles after i_switch_reg_bus_rd, one cycle wide; rd_dout = 0 when not valid.
- Lookup latency 1 cycle. Same-edge host write and lookup of the same entry returns the old value.
- o_stat_req rises 2 cycles after the start strobe and stays high until the ack cycle inclusive; drops the cycle after ack or timeout.
- busy readable on the cycle after o_stat_req rises; done/err set the cycle after ack/timeout.
- Ack coinciding with the timeout cycle counts as ack.
- Reset asserted mid-snapshot: FSM to IDLE, shadow and flags cleared immediately.

## Configuration
- CB_SNAP_CLEAR_ON_READ_EN defined: o_stat_clr mirrors o_stat_req, so the statistics block zeroes the stream's counters on ack; counters read as deltas since last snapshot.
- Not defined: o_stat_clr tied 0; counters are cumulative.

## Test plan
- Reset, read 0x02 with STREAM_SEL=0 → 0x0004; read 0x03 → 0x03E8; read 0x11 → STREAM_NUM.
- Write STREAM_SEL=5, HIST_LEN=0x50 → read 0x02 returns 0x0020; i_lkup_stream=5 → o_lkup_hist_len=0x20 one cycle later; stream 4 still 0x04.
- STREAM_SEL=9, start snapshot, ack after 10 cycles with passed=0x1122_3344_5566_7788 → o_stat_stream=9, reads 0x06..0x09 return 0x7788,0x5566,0x3344,0x1122, SNAP_CTRL=0x2.
- Start snapshot, never ack → o_stat_req drops after SNAP_TIMEOUT cycles, SNAP_CTRL=0x4, shadow unchanged; second start during busy ignored.
- STREAM_SEL=STREAM_NUM, write ALG_ID=0x7 → ignored, read 0x01 returns 0; start → err=1, no o_stat_req.
- With CB_SNAP_CLEAR_ON_READ_EN: o_stat_clr high for the same cycles as o_stat_req; without: always 0.
